// File: rtl/uart_ctl.sv
// ---------------------------------------------------------------------------
// uart_ctl
//
// Bus-master sequencer for a 16550-style uart register port. After reset it
// programs the divisor (DLA set, DLL, DLM, DLA clear). It then polls LSR and
// moves bytes between two 8-bit valid/ready client streams and THR/RBR through
// byte-wide TX and RX FIFOs. The uart is polled, so IER is never written.
//
// Parameters
//   TX_DEPTH       TX FIFO entries (power of 2, >= 2)
//   RX_DEPTH       RX FIFO entries (power of 2, >= 2)
//   RESET_DIV      divisor programmed by the init sequence after reset
//   INIT_ON_RESET  1: run the init sequence after reset, 0: start polling
//
// Ports
//   i_clk, i_rst     clock, synchronous active-high reset
//   o_addr/o_stb/o_we/o_dat_w, i_ack/i_dat_r
//                    uart register port (one transaction per ack, o_we=0 read)
//   i_tx_valid/i_tx_data/o_tx_ready   client -> TX FIFO stream
//   o_rx_valid/o_rx_data/i_rx_ready   RX FIFO -> client stream (fall-through)
//   i_cfg_start/i_cfg_div             request a new divisor
//   o_cfg_busy                        init or reconfiguration in progress
//   o_rx_stall                        sticky: DR seen while the RX FIFO was full
// ---------------------------------------------------------------------------
module uart_ctl #(
  parameter int          TX_DEPTH      = 16,
  parameter int          RX_DEPTH      = 16,
  parameter logic [15:0] RESET_DIV     = 16'd3334,
  parameter bit          INIT_ON_RESET = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic [2:0]  o_addr,
  output logic        o_stb,
  output logic [3:0]  o_we,
  input  logic        i_ack,
  output logic [31:0] o_dat_w,
  input  logic [31:0] i_dat_r,
  input  logic        i_tx_valid,
  input  logic [7:0]  i_tx_data,
  output logic        o_tx_ready,
  output logic        o_rx_valid,
  output logic [7:0]  o_rx_data,
  input  logic        i_rx_ready,
  input  logic        i_cfg_start,
  input  logic [15:0] i_cfg_div,
  output logic        o_cfg_busy,
  output logic        o_rx_stall
);

  localparam int TX_AW = (TX_DEPTH > 1) ? $clog2(TX_DEPTH) : 1;
  localparam int TX_CW = $clog2(TX_DEPTH + 1);
  localparam int RX_AW = (RX_DEPTH > 1) ? $clog2(RX_DEPTH) : 1;
  localparam int RX_CW = $clog2(RX_DEPTH + 1);

  localparam logic [2:0] ADDR_DATA = 3'd0;
  localparam logic [2:0] ADDR_DLM  = 3'd1;
  localparam logic [2:0] ADDR_LCR  = 3'd3;
  localparam logic [2:0] ADDR_LSR  = 3'd5;

  typedef enum logic [2:0] {
    S_I_LCR1,
    S_I_DLL,
    S_I_DLM,
    S_I_LCR0,
    S_POLL,
    S_RD,
    S_WR,
    S_DRAIN
  } state_e;

  state_e state_q, state_d;

  // started_q keeps the bus quiet for the first cycle after reset so that
  // a reset asserted mid-transaction drops o_stb on the very next cycle.
  logic        started_q;
  logic [15:0] div_q;
  logic        busy_q;
  logic        pending_q;
  logic        preferRd_q;
  logic        stall_q;

  logic        adv;
  logic        lsrDr, lsrThe, lsrTemt;
  logic        rdOk, wrOk;
  logic        goRd, goWr, toDrain, initDone, stallSet;

  logic [7:0]       txMem [TX_DEPTH];
  logic [TX_AW-1:0] txWrPtr_q, txRdPtr_q;
  logic [TX_CW-1:0] txCount_q;
  logic             txFull, txEmpty, txPush, txPop;
  logic [7:0]       txHead;

  logic [7:0]       rxMem [RX_DEPTH];
  logic [RX_AW-1:0] rxWrPtr_q, rxRdPtr_q;
  logic [RX_CW-1:0] rxCount_q;
  logic             rxFull, rxEmpty, rxPush, rxPop;

  logic unusedDat;
  assign unusedDat = ^{i_dat_r[31:15], i_dat_r[12:9]};

  assign adv     = started_q & i_ack;
  assign lsrDr   = i_dat_r[8];
  assign lsrThe  = i_dat_r[13];
  assign lsrTemt = i_dat_r[14];

  // RBR is only read when a byte is waiting and there is room for it, since
  // the read itself clears DR in the uart.
  assign rdOk = lsrDr & ~rxFull;
  assign wrOk = lsrThe & ~txEmpty;

  // Next-state logic. Every state is a bus transaction, so the FSM only
  // moves in the ack cycle; the POLL decision is made from the LSR value
  // returned in that same cycle.
  always_comb begin
    state_d  = state_q;
    goRd     = 1'b0;
    goWr     = 1'b0;
    toDrain  = 1'b0;
    initDone = 1'b0;
    stallSet = 1'b0;
    case (state_q)
      S_I_LCR1: if (adv) state_d = S_I_DLL;
      S_I_DLL:  if (adv) state_d = S_I_DLM;
      S_I_DLM:  if (adv) state_d = S_I_LCR0;
      S_I_LCR0: begin
        if (adv) begin
          state_d  = S_POLL;
          initDone = 1'b1;
        end
      end
      S_POLL: begin
        if (adv) begin
          stallSet = lsrDr & rxFull;
          if (pending_q) begin
            state_d = S_DRAIN;
            toDrain = 1'b1;
          end else if (rdOk && wrOk) begin
            goRd = preferRd_q;
            goWr = ~preferRd_q;
          end else begin
            goRd = rdOk;
            goWr = wrOk;
          end
          if (goRd) state_d = S_RD;
          else if (goWr) state_d = S_WR;
        end
      end
      S_RD:    if (adv) state_d = S_POLL;
      S_WR:    if (adv) state_d = S_POLL;
      S_DRAIN: if (adv && lsrTemt) state_d = S_I_LCR1;
      default: state_d = S_POLL;
    endcase
  end

  // Bus outputs are a pure decode of the registered state; before the
  // first post-reset cycle everything sits at zero.
  always_comb begin
    o_stb   = 1'b0;
    o_addr  = 3'd0;
    o_we    = 4'd0;
    o_dat_w = 32'd0;
    if (started_q) begin
      o_stb = 1'b1;
      case (state_q)
        S_I_LCR1: begin
          o_addr  = ADDR_LCR;
          o_we    = 4'b1000;
          o_dat_w = 32'h8000_0000;
        end
        S_I_DLL: begin
          o_addr  = ADDR_DATA;
          o_we    = 4'b0001;
          o_dat_w = {24'd0, div_q[7:0]};
        end
        S_I_DLM: begin
          o_addr  = ADDR_DLM;
          o_we    = 4'b0010;
          o_dat_w = {16'd0, div_q[15:8], 8'd0};
        end
        S_I_LCR0: begin
          o_addr = ADDR_LCR;
          o_we   = 4'b1000;
        end
        S_POLL:  o_addr = ADDR_LSR;
        S_RD:    o_addr = ADDR_DATA;
        S_WR: begin
          o_addr  = ADDR_DATA;
          o_we    = 4'b0001;
          o_dat_w = {24'd0, txHead};
        end
        S_DRAIN: o_addr = ADDR_LSR;
        default: o_stb = 1'b0;
      endcase
    end
  end

  // Control registers. A reconfig request is latched as pending and only
  // acted on at the next POLL decision, so an RD/WR in flight completes.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= INIT_ON_RESET ? S_I_LCR1 : S_POLL;
      started_q  <= 1'b0;
      div_q      <= RESET_DIV;
      busy_q     <= INIT_ON_RESET;
      pending_q  <= 1'b0;
      preferRd_q <= 1'b1;
      stall_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      started_q <= 1'b1;
      if (goRd) preferRd_q <= 1'b0;
      else if (goWr) preferRd_q <= 1'b1;
      if (stallSet) stall_q <= 1'b1;
      if (initDone) busy_q <= 1'b0;
      if (toDrain) pending_q <= 1'b0;
      if (i_cfg_start && !busy_q) begin
        div_q     <= i_cfg_div;
        busy_q    <= 1'b1;
        pending_q <= 1'b1;
      end
    end
  end

  assign o_cfg_busy = busy_q;
  assign o_rx_stall = stall_q;

  // TX FIFO: client pushes, WR pops in its ack cycle.
  assign txFull     = (txCount_q == TX_CW'(TX_DEPTH));
  assign txEmpty    = (txCount_q == '0);
  assign txPush     = i_tx_valid & ~txFull;
  assign txPop      = (state_q == S_WR) & adv;
  assign txHead     = txMem[txRdPtr_q];
  assign o_tx_ready = ~txFull;

  always_ff @(posedge i_clk) begin
    if (txPush) txMem[txWrPtr_q] <= i_tx_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      txWrPtr_q <= '0;
      txRdPtr_q <= '0;
      txCount_q <= '0;
    end else begin
      if (txPush) txWrPtr_q <= txWrPtr_q + TX_AW'(1);
      if (txPop)  txRdPtr_q <= txRdPtr_q + TX_AW'(1);
      case ({txPush, txPop})
        2'b10:   txCount_q <= txCount_q + TX_CW'(1);
        2'b01:   txCount_q <= txCount_q - TX_CW'(1);
        default: txCount_q <= txCount_q;
      endcase
    end
  end

  // RX FIFO: RD pushes the RBR byte, client pops the fall-through head.
  // An RD push is only ever scheduled when the FIFO had room at POLL, and
  // only the client can change the count in between, so it cannot overflow.
  assign rxFull     = (rxCount_q == RX_CW'(RX_DEPTH));
  assign rxEmpty    = (rxCount_q == '0);
  assign rxPush     = (state_q == S_RD) & adv;
  assign rxPop      = i_rx_ready & ~rxEmpty;
  assign o_rx_valid = ~rxEmpty;
  assign o_rx_data  = rxMem[rxRdPtr_q];

  always_ff @(posedge i_clk) begin
    if (rxPush) rxMem[rxWrPtr_q] <= i_dat_r[7:0];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rxWrPtr_q <= '0;
      rxRdPtr_q <= '0;
      rxCount_q <= '0;
    end else begin
      if (rxPush) rxWrPtr_q <= rxWrPtr_q + RX_AW'(1);
      if (rxPop)  rxRdPtr_q <= rxRdPtr_q + RX_AW'(1);
      case ({rxPush, rxPop})
        2'b10:   rxCount_q <= rxCount_q + RX_CW'(1);
        2'b01:   rxCount_q <= rxCount_q - RX_CW'(1);
        default: rxCount_q <= rxCount_q;
      endcase
    end
  end

endmodule
